// File: rtl/draw_pkg.sv
// Shared types for the per-frame draw sequencer: FSM states, segment indices
// and the coordinate snapshot layout.
package draw_pkg;
  localparam int COORD_W  = 11;
  localparam int NUM_SEGS = 7;

  typedef logic [2:0] seg_idx_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam seg_idx_t LAST_SEG = seg_idx_t'(NUM_SEGS - 1);
  localparam logic COLOR_BG = 1'b0;
  localparam logic COLOR_FG = 1'b1;

  typedef enum logic [1:0] {IDLE, CLEAR, ERASE, DRAW} state_t;

  // Pipes use ya = gap bottom, yb = gap top; the bird uses them as its two ends.
  typedef struct packed {
    coord_t x;
    coord_t ya;
    coord_t yb;
  } seg_t;

  typedef struct packed {
    seg_t   bird;
    seg_t   pipe1;
    seg_t   pipe2;
    seg_t   pipe3;
    coord_t top;
    coord_t bot;
  } snap_t;
endpackage

// File: rtl/segment_select.sv
// Maps a segment index and a coordinate snapshot to vertical line endpoints:
// 0 = bird, odd = pipe upper part (top..gap top), even = pipe lower part.
module segment_select
  import draw_pkg::*;
(
  input  seg_idx_t seg,
  input  snap_t    snap,
  output coord_t   x0,
  output coord_t   y0,
  output coord_t   x1,
  output coord_t   y1
);
  seg_t pipe;

  always_comb begin
    case (seg)
      3'd1, 3'd2: pipe = snap.pipe1;
      3'd3, 3'd4: pipe = snap.pipe2;
      default:    pipe = snap.pipe3;
    endcase

    x0 = pipe.x;
    x1 = pipe.x;
    y0 = pipe.ya;
    y1 = snap.bot;
    if (seg == 3'd0) begin
      x0 = snap.bird.x;
      x1 = snap.bird.x;
      y0 = snap.bird.ya;
      y1 = snap.bird.yb;
    end else if (seg[0]) begin
      y0 = snap.top;
      y1 = pipe.yb;
    end
  end
endmodule

// File: rtl/frame_draw_sequencer.sv
// Per-frame scheduler for the shared line drawer: snapshots the scene on a
// frame tick, clears or erases the previous frame, then draws the new one.
module frame_draw_sequencer
  import draw_pkg::*;
#(
  parameter int N        = COORD_W,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic [N-1:0] bird_x,
  input  logic [N-1:0] bird_y0,
  input  logic [N-1:0] bird_y1,
  input  logic [N-1:0] pipe1_x,
  input  logic [N-1:0] pipe1_y0,
  input  logic [N-1:0] pipe1_y1,
  input  logic [N-1:0] pipe2_x,
  input  logic [N-1:0] pipe2_y0,
  input  logic [N-1:0] pipe2_y1,
  input  logic [N-1:0] pipe3_x,
  input  logic [N-1:0] pipe3_y0,
  input  logic [N-1:0] pipe3_y1,
  input  logic [N-1:0] y_top,
  input  logic [N-1:0] y_bot,
  input  logic         line_done,
  output logic [N-1:0] x0,
  output logic [N-1:0] y0,
  output logic [N-1:0] x1,
  output logic [N-1:0] y1,
  output logic         color,
  output logic         line_start,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun
);
  localparam int CW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SCREEN_W - 1);
  localparam logic [N-1:0]  ROW_LAST = N'(SCREEN_H - 1);

  state_t        state;
  seg_idx_t      seg;
  logic [CW-1:0] col;
  logic          prev_valid;
  snap_t         cur;
  snap_t         prev;
  seg_idx_t      cur_idx;
  seg_idx_t      prev_idx;
  coord_t        cur_x0, cur_y0, cur_x1, cur_y1;
  coord_t        prev_x0, prev_y0, prev_x1, prev_y1;
  logic          done_ok;
  logic          last_draw;

  // A done in the same cycle as our start belongs to no line of ours.
  assign done_ok   = line_done && !line_start;
  assign last_draw = (state == DRAW) && done_ok && (seg == LAST_SEG);
  assign busy      = (state != IDLE);

  // Look one segment ahead so the next line issues on the done edge.
  assign cur_idx  = (state == DRAW)  ? seg_idx_t'(seg + 3'd1) : '0;
  assign prev_idx = (state == ERASE) ? seg_idx_t'(seg + 3'd1) : '0;

  segment_select cur_sel (
    .seg (cur_idx),
    .snap(cur),
    .x0  (cur_x0),
    .y0  (cur_y0),
    .x1  (cur_x1),
    .y1  (cur_y1)
  );

  segment_select prev_sel (
    .seg (prev_idx),
    .snap(prev),
    .x0  (prev_x0),
    .y0  (prev_y0),
    .x1  (prev_x1),
    .y1  (prev_y1)
  );

  always_ff @(posedge clock) begin
    if (!reset && state == IDLE && frame_tick) begin
      cur <= {bird_x, bird_y0, bird_y1,
              pipe1_x, pipe1_y0, pipe1_y1,
              pipe2_x, pipe2_y0, pipe2_y1,
              pipe3_x, pipe3_y0, pipe3_y1,
              y_top, y_bot};
    end
    if (!reset && last_draw) begin
      prev <= cur;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      seg        <= '0;
      col        <= '0;
      prev_valid <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      color      <= COLOR_BG;
      line_start <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      line_start <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= frame_tick && (state != IDLE);

      case (state)
        IDLE: begin
          if (frame_tick) begin
            seg        <= '0;
            col        <= '0;
            color      <= COLOR_BG;
            line_start <= 1'b1;
            if (prev_valid) begin
              state <= ERASE;
              x0    <= prev_x0;
              y0    <= prev_y0;
              x1    <= prev_x1;
              y1    <= prev_y1;
            end else begin
              state <= CLEAR;
              x0    <= '0;
              y0    <= '0;
              x1    <= '0;
              y1    <= ROW_LAST;
            end
          end
        end

        CLEAR: begin
          if (done_ok) begin
            line_start <= 1'b1;
            if (col == COL_LAST) begin
              state <= DRAW;
              seg   <= '0;
              color <= COLOR_FG;
              x0    <= cur_x0;
              y0    <= cur_y0;
              x1    <= cur_x1;
              y1    <= cur_y1;
            end else begin
              col <= col + 1'b1;
              x0  <= N'(col) + N'(1);
              x1  <= N'(col) + N'(1);
              y0  <= '0;
              y1  <= ROW_LAST;
            end
          end
        end

        ERASE: begin
          if (done_ok) begin
            line_start <= 1'b1;
            if (seg == LAST_SEG) begin
              state <= DRAW;
              seg   <= '0;
              color <= COLOR_FG;
              x0    <= cur_x0;
              y0    <= cur_y0;
              x1    <= cur_x1;
              y1    <= cur_y1;
            end else begin
              seg <= seg + 3'd1;
              x0  <= prev_x0;
              y0  <= prev_y0;
              x1  <= prev_x1;
              y1  <= prev_y1;
            end
          end
        end

        DRAW: begin
          if (done_ok) begin
            if (seg == LAST_SEG) begin
              state      <= IDLE;
              seg        <= '0;
              prev_valid <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              line_start <= 1'b1;
              seg        <= seg + 3'd1;
              x0         <= cur_x0;
              y0         <= cur_y0;
              x1         <= cur_x1;
              y1         <= cur_y1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/frame_draw_sequencer.md
# frame_draw_sequencer

Per-frame scheduler for the shared line drawer. On each frame tick it snapshots the bird and three pipe positions, then feeds the line drawer one vertical segment at a time over a start/done handshake. On the first frame after reset it wipes the whole screen; on later frames it erases only the previous frame's segments before drawing the new ones. It sits between the game-state logic (bird and pipe coordinates) and the line-drawer/frame-buffer write path.

## Interface
- N, 11, coordinate width
- SCREEN_W, 640, screen width in pixels; clear sweep column count
- SCREEN_H, 480, screen height in pixels; clear sweep spans rows 0..SCREEN_H-1
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse requesting a new frame
- bird_x, bird_y0, bird_y1  in  N each  bird segment endpoints
- pipe1_x, pipe1_y0, pipe1_y1  in  N each  pipe 1: x, gap bottom (y0), gap top (y1)
- pipe2_x, pipe2_y0, pipe2_y1  in  N each  pipe 2: x, gap bottom (y0), gap top (y1)
- pipe3_x, pipe3_y0, pipe3_y1  in  N each  pipe 3: x, gap bottom (y0), gap top (y1)
- y_top, y_bot  in  N each  playfield top and bottom rows
- line_done  in  1  one-cycle pulse from the line drawer: current line is finished
- x0, y0, x1, y1  out  N each  line endpoints to the line drawer
- color  out  1  line colour: 0 = background, 1 = foreground
- line_start  out  1  one-cycle pulse: begin drawing the current endpoints
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  one-cycle pulse after the last draw completes
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy

## Operation
- Segment index s runs 0..6. Endpoints for each s:
  - s=0: (bird_x, bird_y0)-(bird_x, bird_y1)
  - s=1: (pipe1_x, y_top)-(pipe1_x, pipe1_y1)
  - s=2: (pipe1_x, pipe1_y0)-(pipe1_x, y_bot)
  - s=3,4: the same pair of segments for pipe2
  - s=5,6: the same pair of segments for pipe3
- Registers:
  - cur snapshot: 7 coordinate sets, captured on an accepted frame_tick.
  - prev snapshot: 7 coordinate sets, loaded from cur when a DRAW pass completes.
  - prev_valid: cleared by reset.
- States:
  - IDLE → CLEAR on frame_tick if !prev_valid; IDLE → ERASE on frame_tick if prev_valid.
  - CLEAR: column c = 0..SCREEN_W-1. Draws (c, 0)-(c, SCREEN_H-1) with color 0. After the last column's done → DRAW with s=0.
  - ERASE: s = 0..6 from prev, color 0. After s=6 done → DRAW with s=0.
  - DRAW: s = 0..6 from cur, color 1. After s=6 done: prev ← cur, prev_valid ← 1, pulse frame_done, go to IDLE.
- Only one line is outstanding at a time. The next line_start is issued only after line_done is received for the current line.
- x0, y0, x1, y1 and color are held stable from the line_start cycle through the line_done cycle.
- line_done is ignored in IDLE and in the line_start cycle itself.
- frame_tick while busy: the frame is not restarted, the snapshot is not changed, and overrun pulses for one cycle.
- Live inputs that change mid-frame have no effect; only the snapshot is used.
- Column counter width is $clog2(SCREEN_W). Coordinates pass through unmodified; no arithmetic is performed on them.

## Timing
- Reset values:
  - state IDLE, counters 0, prev_valid 0.
  - x0, y0, x1, y1 = 0; color = 0.
  - line_start, busy, frame_done, overrun = 0.
- Reset mid-frame: on the next edge, line_start is low and the frame is abandoned. The next frame performs a full CLEAR.
- frame_tick sampled at edge k: snapshot, state, endpoints and line_start are all registered at edge k. busy and line_start are high in cycle k+1.
- line_done sampled at edge m: next endpoints and line_start are registered at edge m, so zero idle cycles between lines.
- frame_done is registered on the edge that samples the final DRAW done.
- Frame cost: 7 + 7 line times, or SCREEN_W + 7 on a CLEAR frame, plus 0 overhead cycles.

## Structure
- Package draw_pkg holds:
  - state enum {IDLE, CLEAR, ERASE, DRAW}
  - NUM_SEGS = 7
  - seg_idx_t (3 bits)
  - COLOR_BG = 0, COLOR_FG = 1
  - packed struct seg_t {x, ya, yb}
- One combinational sub-module, segment_select, maps (s, snapshot) to endpoints. It is instantiated twice, once for cur and once for prev.

## Test plan
- Reset with all inputs held, then release: all outputs 0 and busy=0 for 5 cycles.
- SCREEN_W=4, SCREEN_H=8, first frame_tick, line_done returned 3 cycles after each start:
  - 4 starts at (c,0)-(c,7), c=0..3, color 0;
  - then 7 starts color 1 matching the segment order;
  - frame_done once, busy drops the next cycle.
- Second frame after bird_y0 changes 100→120: 7 erase lines use bird_y0=100, then 7 draw lines use 120. Inputs changed mid-frame are not reflected.
- frame_tick pulsed while in DRAW at s=3: overrun pulses once and the line sequence is unchanged.
- Reset asserted while waiting for done at ERASE s=2: line_start stays low afterwards, and the next frame_tick starts CLEAR at column 0.
- line_done held 0 for 50 cycles: endpoints stable and no second line_start. A stray line_done in IDLE produces no line_start.
